bcd_updown_counter: RTL and testbench

//  Multi-digit BCD up/down counter with true per-digit carry/borrow, parallel load and a terminal-count pulse.

---
 rtl/bcd_updown_counter_pkg.sv | 10 +
 rtl/bcd_updown_counter_if.sv | 17 +
 rtl/bcd_updown_counter_digit.sv | 43 ++++
 rtl/bcd_updown_counter.sv | 71 +++++++
 tb/tb_bcd_updown_counter.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/bcd_updown_counter_pkg.sv
// Shared BCD digit type and load clamp helper for the up/down counter.
package bcd_pkg;
   localparam int BCD_W = 4;

   typedef logic [BCD_W-1:0] bcd_digit_t;

   function automatic bcd_digit_t bcd_clamp(input bcd_digit_t val, input bcd_digit_t max);
      return (val > max) ? max : val;
   endfunction
endpackage

// File: rtl/bcd_updown_counter_if.sv
// Control/data bundle between a counter user (master) and the BCD counter (slave).
interface bcd_updown_counter_if #(
   parameter int DIGITS = 6,
   parameter int W      = 4
);
   logic                clr;
   logic                ce;
   logic                up;
   logic                load;
   logic [DIGITS*W-1:0] load_val;
   logic [DIGITS*W-1:0] cnt;
   logic                tc;
   logic                zero;

   modport master (output clr, ce, up, load, load_val, input cnt, tc, zero);
   modport slave  (input clr, ce, up, load, load_val, output cnt, tc, zero);
endinterface

// File: rtl/bcd_updown_counter_digit.sv
// One BCD digit register with its own modulus; priority clr > load > step.
module bcd_digit
   import bcd_pkg::*;
#(
   parameter int DMAX = 9
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       step_i,
   input  logic       up_i,
   input  logic       load_i,
   input  bcd_digit_t load_d_i,
   input  logic       clr_i,
   output bcd_digit_t q_o,
   output logic       at_max_o,
   output logic       at_zero_o
);
   localparam bcd_digit_t DMAX_D = bcd_digit_t'(DMAX);

   bcd_digit_t q_q;
   bcd_digit_t q_d;

   assign at_max_o  = (q_q == DMAX_D);
   assign at_zero_o = (q_q == '0);
   assign q_o       = q_q;

   always_comb begin
      q_d = q_q;
      if (clr_i) begin
         q_d = '0;
      end else if (load_i) begin
         q_d = bcd_clamp(load_d_i, DMAX_D);
      end else if (step_i) begin
         if (up_i) q_d = at_max_o  ? '0     : q_q + 4'd1;
         else      q_d = at_zero_o ? DMAX_D : q_q - 4'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) q_q <= '0;
      else     q_q <= q_d;
   end
endmodule

// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with single-cycle carry/borrow chain and terminal count.
// Define BCD_CNT_SATURATE_EN to hold at the limit instead of wrapping.
module bcd_updown_counter
   import bcd_pkg::*;
#(
   parameter int DIGITS  = 6,
   parameter int W       = 4,
   parameter int MAX     = 9,
   parameter int TOP_MAX = 9
) (
   input  logic               clk,
   input  logic               rst,
   bcd_updown_counter_if.slave bus
);
   logic [DIGITS-1:0]   at_max;
   logic [DIGITS-1:0]   at_zero;
   logic [DIGITS-1:0]   step;
   logic [DIGITS*W-1:0] cnt_w;
   logic                at_limit;
   logic                ce_eff;
   logic                tc_q;
   logic                tc_d;

   assign at_limit = bus.up ? (&at_max) : (&at_zero);

`ifdef BCD_CNT_SATURATE_EN
   assign ce_eff = bus.ce & ~at_limit;
`else
   assign ce_eff = bus.ce;
`endif

   // Digit i steps only when every lower digit is at its carry/borrow point.
   always_comb begin
      logic acc;
      acc = ce_eff;
      for (int i = 0; i < DIGITS; i++) begin
         step[i] = acc;
         acc     = acc & (bus.up ? at_max[i] : at_zero[i]);
      end
   end

   generate
      for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
         bcd_digit #(
            .DMAX ((gi == DIGITS-1) ? TOP_MAX : MAX)
         ) u_digit (
            .clk       (clk),
            .rst       (rst),
            .step_i    (step[gi]),
            .up_i      (bus.up),
            .load_i    (bus.load),
            .load_d_i  (bus.load_val[gi*W +: W]),
            .clr_i     (bus.clr),
            .q_o       (cnt_w[gi*W +: W]),
            .at_max_o  (at_max[gi]),
            .at_zero_o (at_zero[gi])
         );
      end
   endgenerate

   assign tc_d = bus.ce & ~bus.clr & ~bus.load & at_limit;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) tc_q <= 1'b0;
      else     tc_q <= tc_d;
   end

   assign bus.cnt  = cnt_w;
   assign bus.tc   = tc_q;
   assign bus.zero = (cnt_w == '0);
endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed and randomized checks of bcd_updown_counter (3 digits, MS digit 0-5).
// Honors BCD_CNT_SATURATE_EN for the saturating variant.
module tb_bcd_updown_counter;
   localparam int DIGITS  = 3;
   localparam int W       = 4;
   localparam int MAX     = 9;
   localparam int TOP_MAX = 5;
   localparam int MODULUS = 600;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;
   int   m;
   logic exp_tc;

   bcd_updown_counter_if #(.DIGITS(DIGITS), .W(W)) bus ();

   bcd_updown_counter #(
      .DIGITS  (DIGITS),
      .W       (W),
      .MAX     (MAX),
      .TOP_MAX (TOP_MAX)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic clr, input logic load, input logic [11:0] lv,
                        input logic ce, input logic up);
      bus.clr      = clr;
      bus.load     = load;
      bus.load_val = lv;
      bus.ce       = ce;
      bus.up       = up;
   endtask

   function automatic logic [11:0] to_bcd(input int v);
      return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   function automatic int load_value(input logic [11:0] lv);
      int d2, d1, d0;
      d2 = (lv[11:8] > 4'd5) ? 5 : int'(lv[11:8]);
      d1 = (lv[7:4]  > 4'd9) ? 9 : int'(lv[7:4]);
      d0 = (lv[3:0]  > 4'd9) ? 9 : int'(lv[3:0]);
      return d2 * 100 + d1 * 10 + d0;
   endfunction

   initial begin
      drive(1'b0, 1'b0, 12'h000, 1'b0, 1'b0);
      tick();
      tick();
      check("reset_cnt",  32'(bus.cnt),  32'h000);
      check("reset_tc",   32'(bus.tc),   32'h0);
      check("reset_zero", 32'(bus.zero), 32'h1);
      rst = 1'b0;

      // Async reset mid-count.
      drive(1'b0, 1'b1, 12'h123, 1'b0, 1'b1);
      tick();
      check("load_123", 32'(bus.cnt), 32'h123);
      check("nz_zero",  32'(bus.zero), 32'h0);
      drive(1'b0, 1'b0, 12'h000, 1'b1, 1'b1);
      #2 rst = 1'b1;
      #1;
      check("arst_cnt",  32'(bus.cnt),  32'h000);
      check("arst_tc",   32'(bus.tc),   32'h0);
      check("arst_zero", 32'(bus.zero), 32'h1);
      #1 rst = 1'b0;
      drive(1'b0, 1'b0, 12'h000, 1'b0, 1'b1);
      tick();

      // Carry across two digits.
      drive(1'b0, 1'b1, 12'h199, 1'b0, 1'b1);
      tick();
      drive(1'b0, 1'b0, 12'h000, 1'b1, 1'b1);
      tick();
      check("carry_200", 32'(bus.cnt), 32'h200);
      check("carry_tc0", 32'(bus.tc),  32'h0);
      tick();
      check("carry_201", 32'(bus.cnt), 32'h201);
      check("carry_tc1", 32'(bus.tc),  32'h0);

      // Up at all-max.
      drive(1'b0, 1'b1, 12'h599, 1'b0, 1'b1);
      tick();
      check("ld599_tc", 32'(bus.tc), 32'h0);
      drive(1'b0, 1'b0, 12'h000, 1'b1, 1'b1);
      tick();
`ifdef BCD_CNT_SATURATE_EN
      check("sat_up_cnt",  32'(bus.cnt), 32'h599);
      check("sat_up_tc",   32'(bus.tc),  32'h1);
      tick();
      check("sat_up_cnt2", 32'(bus.cnt), 32'h599);
      check("sat_up_tc2",  32'(bus.tc),  32'h1);
`else
      check("wrap_up_cnt", 32'(bus.cnt), 32'h000);
      check("wrap_up_tc",  32'(bus.tc),  32'h1);
      tick();
      check("after_wrap_cnt", 32'(bus.cnt), 32'h001);
      check("after_wrap_tc",  32'(bus.tc),  32'h0);
`endif
      drive(1'b0, 1'b0, 12'h000, 1'b0, 1'b1);
      tick();
      check("idle_tc", 32'(bus.tc), 32'h0);

      // Down at all-zero.
      drive(1'b0, 1'b1, 12'h000, 1'b0, 1'b0);
      tick();
      drive(1'b0, 1'b0, 12'h000, 1'b1, 1'b0);
      tick();
`ifdef BCD_CNT_SATURATE_EN
      check("sat_dn_cnt", 32'(bus.cnt), 32'h000);
      check("sat_dn_tc",  32'(bus.tc),  32'h1);
      tick();
      check("sat_dn_cnt2", 32'(bus.cnt), 32'h000);
`else
      check("wrap_dn_cnt", 32'(bus.cnt), 32'h599);
      check("wrap_dn_tc",  32'(bus.tc),  32'h1);
      tick();
      check("dn_598",    32'(bus.cnt), 32'h598);
      check("dn_598_tc", 32'(bus.tc),  32'h0);
`endif

      // Clamp, clr priority, load priority over ce, direction change, borrow.
      drive(1'b0, 1'b1, 12'h7AF, 1'b0, 1'b1);
      tick();
      check("clamp_7af", 32'(bus.cnt), 32'h599);
      drive(1'b1, 1'b1, 12'h123, 1'b1, 1'b1);
      tick();
      check("clr_wins",      32'(bus.cnt),  32'h000);
      check("clr_wins_zero", 32'(bus.zero), 32'h1);
      drive(1'b0, 1'b1, 12'h042, 1'b1, 1'b1);
      tick();
      check("load_over_ce", 32'(bus.cnt), 32'h042);
      drive(1'b0, 1'b0, 12'h000, 1'b1, 1'b1);
      tick();
      check("up_043", 32'(bus.cnt), 32'h043);
      bus.up = 1'b0;
      tick();
      check("dn_042", 32'(bus.cnt), 32'h042);
      drive(1'b0, 1'b1, 12'h100, 1'b0, 1'b0);
      tick();
      drive(1'b0, 1'b0, 12'h000, 1'b1, 1'b0);
      tick();
      check("borrow_099", 32'(bus.cnt), 32'h099);
      bus.ce = 1'b0;
      tick();
      check("hold_099", 32'(bus.cnt), 32'h099);

      // Randomized run against an integer model.
      drive(1'b1, 1'b0, 12'h000, 1'b0, 1'b0);
      tick();
      m = 0;
      for (int i = 0; i < 2000; i++) begin
         drive(($urandom_range(63) == 0), ($urandom_range(15) == 0), 12'($urandom),
               ($urandom_range(3) != 0), 1'($urandom));
         exp_tc = 1'b0;
         if (bus.clr) begin
            m = 0;
         end else if (bus.load) begin
            m = load_value(bus.load_val);
         end else if (bus.ce) begin
            exp_tc = bus.up ? (m == MODULUS - 1) : (m == 0);
`ifdef BCD_CNT_SATURATE_EN
            if (bus.up && m < MODULUS - 1) m = m + 1;
            else if (!bus.up && m > 0)     m = m - 1;
`else
            m = bus.up ? (m + 1) % MODULUS : (m + MODULUS - 1) % MODULUS;
`endif
         end
         tick();
         check("rand_cnt",  32'(bus.cnt),  32'(to_bcd(m)));
         check("rand_tc",   32'(bus.tc),   32'(exp_tc));
         check("rand_zero", 32'(bus.zero), 32'(m == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
